// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int unsigned UART_MIN_OVERSAMPLE = 8;

    // Terminal count of the oversample tick divider.
    function automatic int unsigned tick_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample) - 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Synchronous FIFO with combinational head; push while full is accepted only with a pop.
module uart_rx_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_c, pop_ok_c;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop_ok_c  = pop & ~empty;
    assign push_ok_c = push & (~full | pop_ok_c);
    assign count     = count_q;
    assign head      = empty ? '0 : mem_q[rd_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok_c) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
        end
        if (pop_ok_c) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote, framing check and receive FIFO.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          data,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err,
    input  logic                          clear_err
);

    localparam int unsigned TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned TICK_W   = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam int unsigned OS_W     = $clog2(OVERSAMPLE);
    localparam int unsigned MID      = OVERSAMPLE / 2;
    localparam int unsigned BIT_W    = 4;

    if (OVERSAMPLE < UART_MIN_OVERSAMPLE || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 ||
        DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_cfg_check
        $error("uart_rx_fifo: illegal parameter set");
    end

    logic                 sync1_q, sync2_q;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    uart_rx_state_t       state_q, state_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 armed_q, armed_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 par_bad_q, par_bad_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 rx_s, tick_c, vote_c, sample_pt_c, bit_end_c;
    logic                 push_c, frame_set_c, parity_set_c;
    logic                 fifo_full, fifo_empty;

    assign rx_s        = sync2_q;
    assign tick_c      = (tick_cnt_q == TICK_W'(TICK_DIV));
    assign tick_cnt_d  = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    assign vote_c      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign sample_pt_c = (os_q == OS_W'(MID + 1));
    assign bit_end_c   = (os_q == OS_W'(OVERSAMPLE - 1));

    // Receive FSM: bit timing, voting, shifting and frame completion.
    always_comb begin
        state_d      = state_q;
        os_d         = os_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        armed_d      = armed_q;
        stop_bad_d   = stop_bad_q;
        par_bad_d    = par_bad_q;
        push_c       = 1'b0;
        frame_set_c  = 1'b0;
        parity_set_c = 1'b0;
        if (tick_c) begin
            if (rx_s) armed_d = 1'b1;
            if (state_q == IDLE) begin
                if (armed_q && !rx_s) begin
                    state_d    = START;
                    armed_d    = 1'b0;
                    os_d       = OS_W'(1);
                    stop_bad_d = 1'b0;
                    par_bad_d  = 1'b0;
                end
            end else begin
                os_d = bit_end_c ? '0 : os_q + OS_W'(1);
                if (os_q == OS_W'(MID - 1)) samp_d[0] = rx_s;
                if (os_q == OS_W'(MID))     samp_d[1] = rx_s;
                case (state_q)
                    START: begin
                        if (sample_pt_c && vote_c) begin
                            state_d = IDLE;
                        end else if (bit_end_c) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end
                    end
                    DATA: begin
                        if (sample_pt_c) shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
                        if (bit_end_c) begin
                            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                                state_d = PARITY;
`else
                                state_d = STOP;
`endif
                            end else begin
                                bit_d = bit_q + BIT_W'(1);
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (sample_pt_c) par_bad_d = vote_c ^ (^shift_q) ^ 1'(PARITY_ODD);
                        if (bit_end_c) state_d = STOP;
                    end
`endif
                    STOP: begin
                        if (sample_pt_c) begin
                            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                                state_d = IDLE;
                                if (stop_bad_q || !vote_c) frame_set_c  = 1'b1;
                                else if (par_bad_q)        parity_set_c = 1'b1;
                                else                       push_c       = 1'b1;
                            end else begin
                                stop_bad_d = stop_bad_q | ~vote_c;
                            end
                        end else if (bit_end_c) begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Sticky error flags; a set in the same cycle as clear_err wins.
    always_comb begin
        overrun_d    = (push_c & fifo_full & ~data_ready) | (overrun_q & ~clear_err);
        frame_err_d  = frame_set_c | (frame_err_q & ~clear_err);
        parity_err_d = parity_set_c | (parity_err_q & ~clear_err);
    end

    // Synchroniser, tick divider, FSM and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            tick_cnt_q   <= '0;
            state_q      <= IDLE;
            os_q         <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            armed_q      <= 1'b0;
            stop_bad_q   <= 1'b0;
            par_bad_q    <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            tick_cnt_q   <= tick_cnt_d;
            state_q      <= state_d;
            os_q         <= os_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            armed_q      <= armed_d;
            stop_bad_q   <= stop_bad_d;
            par_bad_q    <= par_bad_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    uart_rx_fifo_mem #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata (shift_q),
        .pop   (data_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (data)
    );

    assign data_valid = ~fifo_empty;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
